// File: rtl/trivium_ctrl_if.sv
// Host-side bundle for trivium_ctrl.
//   master : host/consumer side. Drives start, abort, key_in, iv_in, nbytes, ks_ready.
//   slave  : controller side. Drives ks_data, ks_valid, busy, done.
// Signals:
//   start     1-cycle request, accepted only while the controller is idle
//   abort     synchronous abort back to idle
//   key_in    80-bit key, sampled with an accepted start
//   iv_in     80-bit IV, sampled with an accepted start
//   nbytes    number of keystream bytes to produce
//   ks_data   packed keystream byte, first generated bit in bit 7
//   ks_valid  ks_data valid
//   ks_ready  consumer accepts when ks_valid & ks_ready
//   busy      controller not idle
//   done      1-cycle pulse once the last byte has been accepted
interface trivium_ctrl_if;
    logic        start;
    logic        abort;
    logic [79:0] key_in;
    logic [79:0] iv_in;
    logic [15:0] nbytes;
    logic [7:0]  ks_data;
    logic        ks_valid;
    logic        ks_ready;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output abort,
        output key_in,
        output iv_in,
        output nbytes,
        output ks_ready,
        input  ks_data,
        input  ks_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  abort,
        input  key_in,
        input  iv_in,
        input  nbytes,
        input  ks_ready,
        output ks_data,
        output ks_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/trivium_ctrl.sv
// Sequencer for a single Trivium keystream core.
// A start request latches key/IV/byte count, pulses the core's active-low load strobe
// for one cycle, runs WARMUP enabled cycles, then clocks the core 8 cycles per byte.
// Bits are packed MSB-first and handed out on a valid/ready port; done pulses after
// the last byte is accepted. This block is the only driver of the core's controls.
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          asynchronous active-low reset
//   host         trivium_ctrl_if.slave: start/abort/key_in/iv_in/nbytes in,
//                ks_data/ks_valid/busy/done out, ks_ready in
//   core_rst     active-low load strobe to the core (registered)
//   core_enable  core step enable (registered)
//   core_key     latched key, stable from load until the next accepted start
//   core_iv      latched IV, stable from load until the next accepted start
//   core_ks_bit  core keystream bit, valid the cycle after an enabled cycle
module trivium_ctrl #(
    parameter int unsigned WARMUP = 1152,
    parameter int unsigned CNT_W  = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    trivium_ctrl_if.slave        host,
    output logic                 core_rst,
    output logic                 core_enable,
    output logic [79:0]          core_key,
    output logic [79:0]          core_iv,
    input  logic                 core_ks_bit
);

    localparam logic [CNT_W-1:0] WarmLast = CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0] GenLast  = CNT_W'(7);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWarm,
        StGen,
        StCap,
        StPresent,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      bytes_left_q, bytes_left_d;
    logic [7:0]       acc_q, acc_d;
    logic [79:0]      key_q, key_d;
    logic [79:0]      iv_q, iv_d;
    logic [7:0]       ks_data_q, ks_data_d;
    logic             ks_valid_q, ks_valid_d;
    logic             core_rst_q, core_rst_d;
    logic             core_enable_q, core_enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Decoded requests seen in idle; abort always wins over start.
    logic start_ok;
    logic start_load;
    logic start_empty;
    logic handshake;

    assign start_ok    = (state_q == StIdle) && host.start && !host.abort;
    assign start_load  = start_ok && (host.nbytes != 16'd0);
    assign start_empty = start_ok && (host.nbytes == 16'd0);
    assign handshake   = (state_q == StPresent) && host.ks_ready && !host.abort;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (host.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_load) begin
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    state_d = StWarm;
                end
                StWarm: begin
                    if (cnt_q == WarmLast) begin
                        state_d = StGen;
                    end
                end
                StGen: begin
                    if (cnt_q == GenLast) begin
                        state_d = StCap;
                    end
                end
                StCap: begin
                    state_d = StPresent;
                end
                StPresent: begin
                    if (host.ks_ready) begin
                        state_d = (bytes_left_q == 16'd1) ? StDone : StGen;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d        = '0;
        bytes_left_d = bytes_left_q;
        acc_d        = acc_q;
        key_d        = key_q;
        iv_d         = iv_q;
        ks_data_d    = ks_data_q;

        if (start_load) begin
            key_d        = host.key_in;
            iv_d         = host.iv_in;
            bytes_left_d = host.nbytes;
        end

        if (host.abort) begin
            bytes_left_d = '0;
        end else begin
            unique case (state_q)
                StWarm: begin
                    cnt_d = (cnt_q == WarmLast) ? '0 : cnt_q + 1'b1;
                end
                StGen: begin
                    cnt_d = (cnt_q == GenLast) ? '0 : cnt_q + 1'b1;
                    // The core bit lags its enable by one cycle, so the first GEN cycle
                    // of a byte has nothing new to capture.
                    if (cnt_q != '0) begin
                        acc_d = {acc_q[6:0], core_ks_bit};
                    end
                end
                StCap: begin
                    // Eighth bit arrives here; it goes straight into the output byte.
                    ks_data_d = {acc_q[6:0], core_ks_bit};
                end
                default: begin
                end
            endcase
            if (handshake) begin
                bytes_left_d = bytes_left_q - 16'd1;
            end
        end

        // Registered outputs are decoded from the upcoming state so they line up
        // with the state they describe.
        core_rst_d    = (state_d != StLoad);
        core_enable_d = (state_d == StWarm) || (state_d == StGen);
        ks_valid_d    = (state_d == StPresent);
        busy_d        = (state_d != StIdle);
        done_d        = (state_d == StDone) || start_empty;
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            bytes_left_q  <= '0;
            acc_q         <= '0;
            key_q         <= '0;
            iv_q          <= '0;
            ks_data_q     <= '0;
            ks_valid_q    <= 1'b0;
            core_rst_q    <= 1'b1;
            core_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            bytes_left_q  <= bytes_left_d;
            acc_q         <= acc_d;
            key_q         <= key_d;
            iv_q          <= iv_d;
            ks_data_q     <= ks_data_d;
            ks_valid_q    <= ks_valid_d;
            core_rst_q    <= core_rst_d;
            core_enable_q <= core_enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign core_rst      = core_rst_q;
    assign core_enable   = core_enable_q;
    assign core_key      = key_q;
    assign core_iv       = iv_q;
    assign host.ks_data  = ks_data_q;
    assign host.ks_valid = ks_valid_q;
    assign host.busy     = busy_q;
    assign host.done     = done_q;

endmodule

// File: tb/tb_trivium_ctrl.sv
// Testbench for trivium_ctrl: a behavioural Trivium core answers the controller, and
// a reference keystream computed directly from key/IV supplies the expected bytes.
module tb_trivium_ctrl;

    localparam int WARMUP = 1152;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_rst;
    logic        core_enable;
    logic [79:0] core_key;
    logic [79:0] core_iv;
    logic        core_ks_bit = 1'b0;

    trivium_ctrl_if bus ();

    trivium_ctrl #(
        .WARMUP (WARMUP),
        .CNT_W  (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (bus),
        .core_rst    (core_rst),
        .core_enable (core_enable),
        .core_key    (core_key),
        .core_iv     (core_iv),
        .core_ks_bit (core_ks_bit)
    );

    always #5 clk = ~clk;

    // ---------------- Trivium algorithm ----------------
    function automatic logic [288:1] trv_load(input logic [79:0] k, input logic [79:0] iv);
        logic [288:1] s;
        s = '0;
        for (int i = 0; i < 80; i++) begin
            s[i + 1]  = k[i];
            s[i + 94] = iv[i];
        end
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        return s;
    endfunction

    // Returns {z, next_state}.
    function automatic logic [288:0] trv_step(input logic [288:1] s);
        logic t1, t2, t3, z;
        t1 = s[66] ^ s[93];
        t2 = s[162] ^ s[177];
        t3 = s[243] ^ s[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[91] & s[92]) ^ s[171];
        t2 = t2 ^ (s[175] & s[176]) ^ s[264];
        t3 = t3 ^ (s[286] & s[287]) ^ s[69];
        return {z, s[287:178], t2, s[176:94], t1, s[92:1], t3};
    endfunction

    // Core stand-in: loads on the low strobe, steps and emits a bit per enabled cycle.
    logic [288:1] core_s = '0;
    always @(posedge clk) begin
        if (!core_rst) begin
            core_s <= trv_load(core_key, core_iv);
        end else if (core_enable) begin
            {core_ks_bit, core_s} <= trv_step(core_s);
        end
    end

    // ---------------- Reference keystream ----------------
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    task automatic ref_fill(input logic [79:0] k, input logic [79:0] iv, input int n);
        logic [288:1] s;
        logic [288:0] r;
        logic [7:0]   b;
        exp_q.delete();
        s = trv_load(k, iv);
        for (int i = 0; i < WARMUP; i++) begin
            r = trv_step(s);
            s = r[287:0];
        end
        for (int j = 0; j < n; j++) begin
            b = '0;
            for (int i = 0; i < 8; i++) begin
                r = trv_step(s);
                s = r[287:0];
                b = {b[6:0], r[288]};
            end
            exp_q.push_back(b);
        end
    endtask

    // ---------------- Checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [79:0] got,
                             input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- Per-cycle observation ----------------
    int         cyc;
    int         en_cnt;
    int         rst_low_cnt;
    int         rst_low_cyc;
    int         done_cnt;
    int         done_cyc;
    int         first_valid_cyc;
    int         stall_cnt;
    int         ready_mode;   // 0: always ready, 1: 20-cycle stall per byte, 2: random
    bit         noise;        // random start pulses while busy
    bit         held;
    logic [7:0] held_data;

    task automatic clear_stats();
        cyc             = 0;
        en_cnt          = 0;
        rst_low_cnt     = 0;
        rst_low_cyc     = -1;
        done_cnt        = 0;
        done_cyc        = -1;
        first_valid_cyc = -1;
        stall_cnt       = 0;
        held            = 0;
        rx_q.delete();
    endtask

    // Drive this cycle's inputs, record what the DUT shows, then advance one clock.
    task automatic tick();
        case (ready_mode)
            0:       bus.ks_ready = 1'b1;
            1:       bus.ks_ready = bus.ks_valid && (stall_cnt >= 20);
            default: bus.ks_ready = 1'($urandom_range(0, 1));
        endcase
        if (noise) begin
            if (bus.busy) begin
                bus.start  = ($urandom_range(0, 3) == 0);
                bus.key_in = 80'({$urandom, $urandom, $urandom});
                bus.iv_in  = 80'({$urandom, $urandom, $urandom});
                bus.nbytes = 16'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        if (core_enable) en_cnt++;
        if (!core_rst) begin
            rst_low_cnt++;
            rst_low_cyc = cyc;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.ks_valid) begin
            check_val("enable_while_valid", 80'(core_enable), 80'(0));
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (held) check_val("stall_hold", 80'(bus.ks_data), 80'(held_data));
            if (bus.ks_ready) begin
                rx_q.push_back(bus.ks_data);
                held      = 0;
                stall_cnt = 0;
            end else begin
                held      = 1;
                held_data = bus.ks_data;
                stall_cnt++;
            end
        end else begin
            held = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch(input logic [79:0] k, input logic [79:0] iv, input logic [15:0] n,
                          input int mode, input bit nz);
        clear_stats();
        noise      = 0;
        ready_mode = mode;
        bus.key_in = k;
        bus.iv_in  = iv;
        bus.nbytes = n;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        noise     = nz;
    endtask

    task automatic wait_done(input int budget);
        while (done_cnt == 0 && cyc < budget) tick();
        noise     = 0;
        bus.start = 1'b0;
        check_val("done_seen", 80'(done_cnt), 80'(1));
    endtask

    task automatic compare_stream(input string tag);
        check_val({tag, "_count"}, 80'(rx_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            check_val({tag, "_byte"}, 80'(rx_q[i]), 80'(exp_q[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_core_rst"}, 80'(core_rst), 80'(1));
        check_val({tag, "_core_enable"}, 80'(core_enable), 80'(0));
        check_val({tag, "_core_key"}, core_key, 80'(0));
        check_val({tag, "_core_iv"}, core_iv, 80'(0));
        check_val({tag, "_ks_data"}, 80'(bus.ks_data), 80'(0));
        check_val({tag, "_ks_valid"}, 80'(bus.ks_valid), 80'(0));
        check_val({tag, "_busy"}, 80'(bus.busy), 80'(0));
        check_val({tag, "_done"}, 80'(bus.done), 80'(0));
    endtask

    // ---------------- Stimulus ----------------
    logic [79:0] k, iv;
    int          n;

    initial begin
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.key_in = '0;
        bus.iv_in  = '0;
        bus.nbytes = '0;
        bus.ks_ready = 1'b0;
        noise      = 0;
        ready_mode = 0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        tick();

        // Zero-length request: done next cycle, core untouched.
        k  = 80'({$urandom, $urandom, $urandom});
        iv = 80'({$urandom, $urandom, $urandom});
        launch(k, iv, 16'd0, 0, 0);
        wait_done(50);
        repeat (5) tick();
        check_val("zero_done_cycle", 80'(done_cyc), 80'(1));
        check_val("zero_done_pulses", 80'(done_cnt), 80'(1));
        check_val("zero_core_rst", 80'(rst_low_cnt), 80'(0));
        check_val("zero_core_enable", 80'(en_cnt), 80'(0));

        // All-zero key/IV, single byte, consumer always ready.
        ref_fill(80'(0), 80'(0), 1);
        launch(80'(0), 80'(0), 16'd1, 0, 0);
        wait_done(1400);
        tick();
        check_val("one_rst_low_count", 80'(rst_low_cnt), 80'(1));
        check_val("one_rst_low_cycle", 80'(rst_low_cyc), 80'(1));
        check_val("one_enables", 80'(en_cnt), 80'(WARMUP + 8));
        check_val("one_first_valid", 80'(first_valid_cyc), 80'(WARMUP + 11));
        check_val("one_done_cycle", 80'(done_cyc), 80'(WARMUP + 12));
        compare_stream("one");

        // Four bytes, 20-cycle stall each, with stray start pulses while busy.
        k  = 80'({$urandom, $urandom, $urandom});
        iv = 80'({$urandom, $urandom, $urandom});
        ref_fill(k, iv, 4);
        launch(k, iv, 16'd4, 1, 1);
        wait_done(2500);
        tick();
        check_val("stall_enables", 80'(en_cnt), 80'(WARMUP + 32));
        check_val("stall_done_pulses", 80'(done_cnt), 80'(1));
        check_val("stall_core_key", core_key, k);
        check_val("stall_core_iv", core_iv, iv);
        compare_stream("stall");

        // Reset in the middle of warm-up, then a clean rerun.
        k  = 80'({$urandom, $urandom, $urandom});
        iv = 80'({$urandom, $urandom, $urandom});
        launch(k, iv, 16'd2, 0, 0);
        while (cyc < 500) tick();
        check_val("midwarm_enable_before", 80'(core_enable), 80'(1));
        rst = 1'b0;
        #1;
        check_reset_outputs("midwarm");
        #1;
        rst = 1'b1;
        tick();
        ref_fill(k, iv, 2);
        launch(k, iv, 16'd2, 0, 0);
        wait_done(1400);
        compare_stream("after_reset");

        // Abort while the second of three bytes is on offer.
        k  = 80'({$urandom, $urandom, $urandom});
        iv = 80'({$urandom, $urandom, $urandom});
        ref_fill(k, iv, 3);
        launch(k, iv, 16'd3, 1, 1);
        while (!(rx_q.size() == 1 && bus.ks_valid) && cyc < 2000) tick();
        repeat (3) tick();
        check_val("abort_pre_valid", 80'(bus.ks_valid), 80'(1));
        noise     = 0;
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check_val("abort_ks_valid", 80'(bus.ks_valid), 80'(0));
        check_val("abort_busy", 80'(bus.busy), 80'(0));
        check_val("abort_core_enable", 80'(core_enable), 80'(0));
        check_val("abort_core_rst", 80'(core_rst), 80'(1));
        repeat (5) tick();
        check_val("abort_no_done", 80'(done_cnt), 80'(0));
        check_val("abort_rx_count", 80'(rx_q.size()), 80'(1));
        if (rx_q.size() > 0) check_val("abort_first_byte", 80'(rx_q[0]), 80'(exp_q[0]));

        // Start and abort together in idle: request dropped.
        clear_stats();
        bus.key_in = 80'({$urandom, $urandom, $urandom});
        bus.nbytes = 16'd1;
        bus.start  = 1'b1;
        bus.abort  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (4) tick();
        check_val("startabort_busy", 80'(bus.busy), 80'(0));
        check_val("startabort_core_rst", 80'(rst_low_cnt), 80'(0));
        check_val("startabort_enables", 80'(en_cnt), 80'(0));
        check_val("startabort_done", 80'(done_cnt), 80'(0));

        // Random jobs with a random consumer and stray starts.
        for (int j = 0; j < 3; j++) begin
            k  = 80'({$urandom, $urandom, $urandom});
            iv = 80'({$urandom, $urandom, $urandom});
            n  = $urandom_range(1, 4);
            ref_fill(k, iv, n);
            launch(k, iv, 16'(n), 2, 1);
            wait_done(3000);
            tick();
            check_val("rand_enables", 80'(en_cnt), 80'(WARMUP + 8 * n));
            check_val("rand_rst_low", 80'(rst_low_cnt), 80'(1));
            compare_stream("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
